// File: rtl/except_ctrl_pkg.sv
// ============================================================================
// Module      : except_ctrl_pkg
// Description : Shared exception codes, flag indices, vector and FSM types.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package except_ctrl_pkg;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000A;
  localparam logic [31:0] EXC_OV   = 32'h0000_000C;
  localparam logic [31:0] EXC_TR   = 32'h0000_000D;
  localparam logic [31:0] EXC_ERET = 32'h0000_000E;

  localparam int FLG_ADEL_IF = 0;
  localparam int FLG_RI      = 1;
  localparam int FLG_OV      = 2;
  localparam int FLG_TRAP    = 3;
  localparam int FLG_SYS     = 4;
  localparam int FLG_BRK     = 5;
  localparam int FLG_ADEL_LD = 6;
  localparam int FLG_ADES    = 7;
  localparam int FLG_ERET    = 8;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    BA_NONE = 2'd0,
    BA_IF   = 2'd1,
    BA_MEM  = 2'd2
  } badsel_e;

endpackage

`default_nettype wire

// File: rtl/except_ctrl_prio_enc.sv
// ============================================================================
// Module      : exc_prio_enc
// Description : Fixed-priority resolver from exception flags to excepttype.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exc_prio_enc
  import except_ctrl_pkg::*;
(
  input  logic [8:0]  flags_i,
  input  logic        int_pending_i,
  output logic        hit_o,
  output logic [31:0] excepttype_o,
  output badsel_e     badsel_o
);

  always_comb begin
    hit_o        = 1'b1;
    excepttype_o = '0;
    badsel_o     = BA_NONE;
    if (int_pending_i) begin
      excepttype_o = EXC_INT;
    end else if (flags_i[FLG_ADEL_IF]) begin
      excepttype_o = EXC_ADEL;
      badsel_o     = BA_IF;
    end else if (flags_i[FLG_RI]) begin
      excepttype_o = EXC_RI;
    end else if (flags_i[FLG_OV]) begin
      excepttype_o = EXC_OV;
    end else if (flags_i[FLG_TRAP]) begin
      excepttype_o = EXC_TR;
    end else if (flags_i[FLG_SYS]) begin
      excepttype_o = EXC_SYS;
    end else if (flags_i[FLG_BRK]) begin
      excepttype_o = EXC_BP;
    end else if (flags_i[FLG_ADEL_LD]) begin
      excepttype_o = EXC_ADEL;
      badsel_o     = BA_MEM;
    end else if (flags_i[FLG_ADES]) begin
      excepttype_o = EXC_ADES;
      badsel_o     = BA_MEM;
    end else if (flags_i[FLG_ERET]) begin
      excepttype_o = EXC_ERET;
    end else begin
      hit_o = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/except_ctrl.sv
// ============================================================================
// Module      : except_ctrl
// Description : Exception/interrupt sequencer between MEM stage and cp0_reg.
//               Optional taken-exception counter enabled by EXC_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR      = EXC_VECTOR_DEF,
  parameter int          FLUSH_CYCLES    = 1,
  parameter int          INT_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        mem_valid_i,
  input  logic        stall_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [8:0]  exc_flags_i,
  input  logic [31:0] bad_addr_if_i,
  input  logic [31:0] bad_addr_mem_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic [5:0]  int_sync_o,
  output logic        cp0_en_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] cur_inst_addr_o,
  output logic        in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic        busy_o,
  output logic [31:0] exc_count_o
);

  localparam int CNT_W = 3;

  logic [INT_SYNC_STAGES-1:0][5:0] sync_q;
  state_e                          state_q;
  logic [CNT_W-1:0]                cnt_q;
  logic                            flush_q;
  logic [31:0]                     newpc_q;

  logic        int_pending;
  logic        decide;
  logic        hit;
  logic [31:0] enc_type;
  badsel_e     badsel;
  logic        unused_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= int_i;
      for (int k = 1; k < INT_SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end
  assign int_sync_o = sync_q[INT_SYNC_STAGES-1];

  // Status[0]=IE, Status[1]=EXL; an open exception level masks all interrupts.
  assign int_pending = (|(cause_i[15:8] & status_i[15:8])) & status_i[0] & ~status_i[1];
  assign decide      = (state_q == ST_IDLE) & mem_valid_i & ~stall_i;

  exc_prio_enc u_prio_enc (
    .flags_i       (exc_flags_i),
    .int_pending_i (int_pending),
    .hit_o         (hit),
    .excepttype_o  (enc_type),
    .badsel_o      (badsel)
  );

  assign cp0_en_o        = decide & hit;
  assign excepttype_o    = cp0_en_o ? enc_type : '0;
  assign cur_inst_addr_o = mem_pc_i;
  assign in_delayslot_o  = mem_in_delayslot_i;

  always_comb begin
    bad_addr_o = '0;
    if (cp0_en_o) begin
      case (badsel)
        BA_IF:   bad_addr_o = bad_addr_if_i;
        BA_MEM:  bad_addr_o = bad_addr_mem_i;
        default: bad_addr_o = '0;
      endcase
    end
  end

  // EPC is sampled before the commit edge, so a same-cycle mtc0 EPC is not seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      newpc_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cp0_en_o) begin
            state_q <= ST_FLUSH;
            flush_q <= 1'b1;
            newpc_q <= (enc_type == EXC_ERET) ? epc_i : EXC_VECTOR;
            cnt_q   <= CNT_W'(FLUSH_CYCLES - 1);
          end
        end
        ST_FLUSH: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            flush_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign flush_o = flush_q;
  assign newpc_o = newpc_q;
  assign busy_o  = (state_q != ST_IDLE);

`ifdef EXC_STATS_EN
  logic [31:0] exc_count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_count_q <= '0;
    end else if (cp0_en_o && (excepttype_o != EXC_ERET)) begin
      exc_count_q <= exc_count_q + 32'd1;
    end
  end
  assign exc_count_o = exc_count_q;
`else
  assign exc_count_o = '0;
`endif

  assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

endmodule

`default_nettype wire
